// File: rtl/half_predict_layer1_core.sv
// Hidden layer l[j] = b1[j] + sum_i x[i]*W1[i][j] in binary16; one lane per output, inputs serial; done L1+2 cycles after start.
// Define HALF_PREDICT_LAYER1_RELU_EN to clamp negative non-NaN results to +0 at the output register.
module half_predict_layer1_core #(
  parameter int LAYER1_NEURONS = 784,
  parameter int LAYER2_NEURONS = 50
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [15:0] x  [LAYER1_NEURONS],
  input  logic [15:0] W1 [LAYER1_NEURONS][LAYER2_NEURONS],
  input  logic [15:0] b1 [LAYER2_NEURONS],
  output logic        done,
  output logic [15:0] l  [LAYER2_NEURONS]
);

  localparam int IW = (LAYER1_NEURONS > 1) ? $clog2(LAYER1_NEURONS) : 1;
  localparam logic [IW-1:0] LAST = IW'(LAYER1_NEURONS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FINISH} state_t;

  state_t        state, state_nxt;
  logic          load, run, fin;
  logic [IW-1:0] idx;
  logic [15:0]   acc [LAYER2_NEURONS];
  logic [15:0]   prod [LAYER2_NEURONS];
  logic [15:0]   sum [LAYER2_NEURONS];

  // m carries the leading one at bit 10; g is the first dropped bit, st the OR of the rest.
  function automatic logic [15:0] round_pack(input logic s, input int e, input logic [10:0] m,
                                             input logic g, input logic st);
    logic [11:0] r;
    int          ee;
    r  = {1'b0, m};
    ee = e;
    if (g && (st || m[0])) r = r + 12'd1;
    if (r[11]) begin
      r  = r >> 1;
      ee = ee + 1;
    end
    if (ee >= 31) return {s, 5'h1F, 10'h000};
    if (ee <= 0) return {s, 15'h0000};
    return {s, ee[4:0], r[9:0]};
  endfunction

  function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
    logic        s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [21:0] p;
    int          e;
    s      = a[15] ^ b[15];
    a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'h0);
    b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'h0);
    a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'h0);
    b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'h0);
    a_zero = (a[14:10] == 5'h00);
    b_zero = (b[14:10] == 5'h00);
    if (a_nan || b_nan) return 16'h7E00;
    if (a_inf || b_inf) return (a_zero || b_zero) ? 16'h7E00 : {s, 5'h1F, 10'h000};
    if (a_zero || b_zero) return {s, 15'h0000};
    p = {11'h000, 1'b1, a[9:0]} * {11'h000, 1'b1, b[9:0]};
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) return round_pack(s, e + 1, p[21:11], p[10], |p[9:0]);
    return round_pack(s, e, p[20:10], p[9], |p[8:0]);
  endfunction

  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [15:0] big, sml;
    logic [13:0] ma, mb, n;
    logic [26:0] t;
    logic [14:0] s;
    int          e, d, lz;
    a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'h0);
    b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'h0);
    a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'h0);
    b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'h0);
    a_zero = (a[14:10] == 5'h00);
    b_zero = (b[14:10] == 5'h00);
    if (a_nan || b_nan) return 16'h7E00;
    if (a_inf && b_inf) return (a[15] != b[15]) ? 16'h7E00 : a;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a_zero && b_zero) return {a[15] & b[15], 15'h0000};
    if (a_zero) return b;
    if (b_zero) return a;
    if (a[14:0] >= b[14:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    e = int'(big[14:10]);
    d = int'(big[14:10]) - int'(sml[14:10]);
    if (d > 26) d = 26;
    // Three extra bits below the LSB (guard, round, sticky) keep RNE exact after alignment.
    ma = {1'b1, big[9:0], 3'b000};
    t  = {1'b1, sml[9:0], 16'h0000} >> d;
    mb = t[26:13] | {13'h0000, |t[12:0]};
    if (big[15] == sml[15]) begin
      s = {1'b0, ma} + {1'b0, mb};
      if (s[14]) begin
        n = s[14:1] | {13'h0000, s[0]};
        e = e + 1;
      end else begin
        n = s[13:0];
      end
    end else begin
      s = {1'b0, ma} - {1'b0, mb};
      if (s == 15'h0000) return 16'h0000;
      lz = 0;
      for (int k = 0; k < 14; k++) if (s[k]) lz = 13 - k;
      n = s[13:0] << lz;
      e = e - lz;
    end
    return round_pack(big[15], e, n[13:3], n[2], |n[1:0]);
  endfunction

  function automatic logic [15:0] out_val(input logic [15:0] a);
`ifdef HALF_PREDICT_LAYER1_RELU_EN
    if (a[15] && !((a[14:10] == 5'h1F) && (a[9:0] != 10'h0))) return 16'h0000;
`endif
    return a;
  endfunction

  always_comb begin
    for (int j = 0; j < LAYER2_NEURONS; j++) begin
      prod[j] = fp_mul(x[idx], W1[idx][j]);
      sum[j]  = fp_add(acc[j], prod[j]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    run       = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    begin load = 1'b1; state_nxt = RUN; end
      RUN:     begin run = 1'b1; if (idx == LAST) state_nxt = FINISH; end
      FINISH:  begin fin = 1'b1; state_nxt = IDLE; end
      default: state_nxt = IDLE;
    endcase
  end

  // done is registered alongside l so the pulse and the new results appear in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx  <= '0;
      done <= 1'b0;
      for (int j = 0; j < LAYER2_NEURONS; j++) begin
        acc[j] <= '0;
        l[j]   <= '0;
      end
    end else begin
      done <= fin;
      if (load)     idx <= '0;
      else if (run) idx <= idx + IW'(1);
      for (int j = 0; j < LAYER2_NEURONS; j++) begin
        if (load)     acc[j] <= b1[j];
        else if (run) acc[j] <= sum[j];
        if (fin) l[j] <= out_val(acc[j]);
      end
    end
  end

endmodule

// File: tb/tb_half_predict_layer1_core.sv
// Directed vector bench for half_predict_layer1_core at a reduced size (128 inputs, 3 lanes).
module tb_half_predict_layer1_core;

  localparam int L1 = 128;
  localparam int L2 = 3;
  localparam int NV = 11;
`ifdef HALF_PREDICT_LAYER1_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  typedef logic [2:0][15:0] lane3_t;
  typedef struct {
    logic [15:0] x0, xr, wr;
    lane3_t      w0, b, e;
  } vec_t;

  logic        clk, rstn, start, done;
  logic [15:0] x  [L1];
  logic [15:0] W1 [L1][L2];
  logic [15:0] b1 [L2];
  logic [15:0] l  [L2];

  vec_t vecs [NV];
  int   total = 0;
  int   bad = 0;

  half_predict_layer1_core #(.LAYER1_NEURONS(L1), .LAYER2_NEURONS(L2)) dut (
    .clk(clk), .rstn(rstn), .start(start), .x(x), .W1(W1), .b1(b1), .done(done), .l(l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic lane3_t ln(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    return {c, b, a};
  endfunction

  function automatic vec_t mk(input logic [15:0] x0, input logic [15:0] xr, input logic [15:0] wr,
                              input lane3_t w0, input lane3_t b, input lane3_t e);
    vec_t v;
    v.x0 = x0; v.xr = xr; v.wr = wr; v.w0 = w0; v.b = b; v.e = e;
    return v;
  endfunction

  function automatic logic [15:0] relu_model(input logic [15:0] v);
    if (RELU && v[15] && !(v[14:10] == 5'h1F && v[9:0] != 10'h0)) return 16'h0000;
    return v;
  endfunction

  task automatic check(input string what, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", what, got, want);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    for (int i = 0; i < L1; i++) begin
      x[i] = (i == 0) ? v.x0 : v.xr;
      for (int j = 0; j < L2; j++) W1[i][j] = (i == 0) ? v.w0[j] : v.wr;
    end
    for (int j = 0; j < L2; j++) b1[j] = v.b[j];
  endtask

  // Returns cycles from the start-sampling edge to the first cycle with done high, -1 on timeout.
  task automatic run_pass(input int restart_at, output int lat);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = -1;
    for (int k = 1; k <= L1 + 20; k++) begin
      @(posedge clk); #1;
      if (k == restart_at) start = 1'b1;
      if (k == restart_at + 1) start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_lanes(input string tag, input lane3_t want);
    for (int j = 0; j < L2; j++)
      check($sformatf("%s_l%0d", tag, j), int'(l[j]), int'(relu_model(want[j])));
  endtask

  initial begin
    int lat, np;
    rstn = 1'b1; start = 1'b0;
    for (int i = 0; i < L1; i++) begin
      x[i] = 16'h0;
      for (int j = 0; j < L2; j++) W1[i][j] = 16'h0;
    end
    for (int j = 0; j < L2; j++) b1[j] = 16'h0;

    vecs[0]  = mk(16'h0000, 16'h0000, 16'h3C00, ln(16'h3C00, 16'h3C00, 16'h3C00),
                  ln(16'h3C00, 16'h3C00, 16'h3C00), ln(16'h3C00, 16'h3C00, 16'h3C00));
    vecs[1]  = mk(16'h3C00, 16'h0000, 16'h0000, ln(16'h4000, 16'h4000, 16'h4000),
                  ln(16'h0, 16'h0, 16'h0), ln(16'h4000, 16'h4000, 16'h4000));
    vecs[2]  = mk(16'h3C00, 16'h3C00, 16'h3800, ln(16'h3800, 16'h3800, 16'h3800),
                  ln(16'h0, 16'h0, 16'h0), ln(16'h5400, 16'h5400, 16'h5400));
    vecs[3]  = mk(16'h7BFF, 16'h0000, 16'h0000, ln(16'h7BFF, 16'h7BFF, 16'h7BFF),
                  ln(16'h0, 16'h0, 16'h0), ln(16'h7C00, 16'h7C00, 16'h7C00));
    vecs[4]  = mk(16'h0000, 16'h0000, 16'h3C00, ln(16'h3C00, 16'h3C00, 16'h3C00),
                  ln(16'hBC00, 16'hBC00, 16'hBC00), ln(16'hBC00, 16'hBC00, 16'hBC00));
    vecs[5]  = mk(16'h3C00, 16'h0000, 16'h0000, ln(16'h4000, 16'hC000, 16'h3800),
                  ln(16'h3C00, 16'h3C00, 16'h0000), ln(16'h4200, 16'hBC00, 16'h3800));
    vecs[6]  = mk(16'h7BFF, 16'h0000, 16'h0000, ln(16'h7BFF, 16'hFBFF, 16'h7BFF),
                  ln(16'hFC00, 16'h0000, 16'h0000), ln(16'h7E00, 16'hFC00, 16'h7C00));
    vecs[7]  = mk(16'h3C00, 16'h0000, 16'h0000, ln(16'h3C00, 16'h4000, 16'hBC00),
                  ln(16'hBC00, 16'hC000, 16'h3C00), ln(16'h0000, 16'h0000, 16'h0000));
    vecs[8]  = mk(16'h3C00, 16'h0000, 16'h0000, ln(16'h1000, 16'h1000, 16'h1001),
                  ln(16'h3C00, 16'h3C01, 16'h3C00), ln(16'h3C00, 16'h3C02, 16'h3C01));
    vecs[9]  = mk(16'h0400, 16'h0000, 16'h0000, ln(16'hB800, 16'h3C00, 16'h0200),
                  ln(16'h0, 16'h0, 16'h0), ln(16'h0000, 16'h0400, 16'h0000));
    vecs[10] = mk(16'h3E00, 16'h0000, 16'h0000, ln(16'h3E00, 16'h4200, 16'hBE00),
                  ln(16'h0, 16'h0, 16'h0), ln(16'h4080, 16'h4480, 16'hC080));

    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_done", int'(done), 0);
    check_lanes("reset", ln(16'h0, 16'h0, 16'h0));
    rstn = 1'b1;

    for (int v = 0; v < NV; v++) begin
      @(negedge clk);
      apply_vec(vecs[v]);
      run_pass(0, lat);
      check($sformatf("v%0d_latency", v), lat, L1 + 2);
      check_lanes($sformatf("v%0d", v), vecs[v].e);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", v), int'(done), 0);
    end

    // second start pulse lands in RUN and must not restart or extend the pass
    @(negedge clk);
    apply_vec(vecs[3]);
    run_pass(20, lat);
    check("busy_start_latency", lat, L1 + 2);
    check_lanes("busy_start", vecs[3].e);
    np = 0;
    repeat (L1 + 10) begin
      @(posedge clk); #1;
      if (done) np++;
    end
    check("busy_start_extra_done", np, 0);

    @(negedge clk);
    apply_vec(vecs[0]);
    repeat (10) @(negedge clk);
    check_lanes("hold", vecs[3].e);

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (102) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    check("midreset_done", int'(done), 0);
    check_lanes("midreset", ln(16'h0, 16'h0, 16'h0));
    @(negedge clk); rstn = 1'b1;
    np = 0;
    repeat (L1 + 5) begin
      @(posedge clk); #1;
      if (done) np++;
    end
    check("midreset_no_done", np, 0);
    check("midreset_l0_after", int'(l[0]), 0);

    @(negedge clk);
    apply_vec(vecs[2]);
    run_pass(0, lat);
    check("after_reset_latency", lat, L1 + 2);
    check_lanes("after_reset", vecs[2].e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
